// File: rtl/secuencia_leds_if.sv
// Bus between the LED sequencer and whoever drives it: step source, mode,
// pause, and the LED/wrap outputs. With LED_BRILLO_EN defined the bus also
// carries the 4-bit brightness setting.
interface secuencia_leds_if #(
  parameter int ANCHO = 8
);
  logic             paso;
  logic [1:0]       modo;
  logic             pausa;
  logic [ANCHO-1:0] leds;
  logic             ciclo;
`ifdef LED_BRILLO_EN
  logic [3:0]       brillo;

  modport master (
    output paso,
    output modo,
    output pausa,
    output brillo,
    input  leds,
    input  ciclo
  );

  modport slave (
    input  paso,
    input  modo,
    input  pausa,
    input  brillo,
    output leds,
    output ciclo
  );
`else
  modport master (
    output paso,
    output modo,
    output pausa,
    input  leds,
    input  ciclo
  );

  modport slave (
    input  paso,
    input  modo,
    input  pausa,
    output leds,
    output ciclo
  );
`endif
endinterface

// File: rtl/secuencia_leds.sv
// 8-LED (ANCHO-wide) pattern sequencer for the DE0-Nano LED bank.
// Every value change of the upstream blinker output 'paso' advances the
// selected pattern one step: rotate, bounce, binary count or all-blink.
// 'ciclo' pulses for one clock after the pattern wraps to its start value.
// Optional feature: define LED_BRILLO_EN to add a 4-bit brightness input
// that gates the LEDs with a free-running 16-step PWM.
module secuencia_leds #(
  parameter int ANCHO = 8
) (
  input  logic              clock,
  input  logic              reset,
  secuencia_leds_if.slave   bus
);

  localparam logic [1:0] DESPLAZA = 2'b00;
  localparam logic [1:0] REBOTE   = 2'b01;
  localparam logic [1:0] CONTADOR = 2'b10;
  localparam logic [1:0] PARPADEO = 2'b11;

  // Direction of travel for the bouncing one-hot bit
  typedef enum logic {
    SUBE = 1'b0,
    BAJA = 1'b1
  } dir_t;

  // Step synchroniser / edge detector
  logic             s1;
  logic             s2;
  logic             tick;

  // Mode tracking
  logic [1:0]       modo_q;
  logic             recarga;

  // Pattern state
  dir_t             dir;
  dir_t             dir_n;
  logic [ANCHO-1:0] patron;
  logic [ANCHO-1:0] patron_n;
  logic             vuelta_n;

  // Registered outputs
  logic [ANCHO-1:0] leds_q;
  logic [ANCHO-1:0] leds_n;
  logic             ciclo_q;

`ifdef LED_BRILLO_EN
  logic [3:0]       pwm_cnt;
  logic [3:0]       pwm_cnt_n;
`endif

  // Starting value of each pattern; the one-hot patterns begin at bit 0.
  function automatic logic [ANCHO-1:0] patron_inicial(input logic [1:0] m);
    if ((m == DESPLAZA) || (m == REBOTE)) begin
      return ANCHO'(1);
    end
    return '0;
  endfunction

  // Circular left shift by one position.
  function automatic logic [ANCHO-1:0] rota_izq(input logic [ANCHO-1:0] v);
    return {v[ANCHO-2:0], v[ANCHO-1]};
  endfunction

  // Any level change of paso is a step; paused steps are simply dropped.
  assign tick    = (s1 != s2) & ~bus.pausa;
  // A new mode is seen one cycle before modo_q catches up with it.
  assign recarga = (bus.modo != modo_q);

  // State register: synchroniser, mode copy, pattern, direction, outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      modo_q  <= DESPLAZA;
      dir     <= SUBE;
      patron  <= ANCHO'(1);
      leds_q  <= ANCHO'(1);
      ciclo_q <= 1'b0;
`ifdef LED_BRILLO_EN
      pwm_cnt <= 4'd0;
`endif
    end else begin
      s1      <= bus.paso;
      s2      <= s1;
      modo_q  <= bus.modo;
      dir     <= dir_n;
      patron  <= patron_n;
      leds_q  <= leds_n;
      ciclo_q <= vuelta_n;
`ifdef LED_BRILLO_EN
      pwm_cnt <= pwm_cnt_n;
`endif
    end
  end

  // Next-state logic: a mode reload wins over a step arriving in the same cycle
  always_comb begin
    patron_n = patron;
    dir_n    = dir;
    vuelta_n = 1'b0;
    if (recarga) begin
      patron_n = patron_inicial(bus.modo);
      dir_n    = SUBE;
    end else if (tick) begin
      case (modo_q)
        DESPLAZA: begin
          patron_n = rota_izq(patron);
          vuelta_n = patron[ANCHO-1];
        end
        REBOTE: begin
          if (dir == SUBE) begin
            patron_n = patron << 1;
            // Turn around on arrival so the MSB is shown only once
            if (patron_n[ANCHO-1]) begin
              dir_n = BAJA;
            end
          end else begin
            patron_n = patron >> 1;
            if (patron_n[0]) begin
              dir_n    = SUBE;
              vuelta_n = 1'b1;
            end
          end
        end
        CONTADOR: begin
          patron_n = patron + ANCHO'(1);
          vuelta_n = &patron;
        end
        default: begin
          patron_n = ~patron;
          vuelta_n = &patron;
        end
      endcase
    end
  end

`ifdef LED_BRILLO_EN
  // Output logic: free-running PWM counter gates the next pattern value
  always_comb begin
    pwm_cnt_n = pwm_cnt + 4'd1;
    leds_n    = patron_n & {ANCHO{pwm_cnt_n < bus.brillo}};
  end
`else
  // Output logic: LEDs follow the next pattern value directly
  always_comb begin
    leds_n = patron_n;
  end
`endif

  assign bus.leds  = leds_q;
  assign bus.ciclo = ciclo_q;

endmodule

// File: tb/tb_secuencia_leds.sv
// Self-checking bench for secuencia_leds. Expected LED/ciclo values are
// queued when a step is driven and compared when the step's result is due.
// Build with LED_BRILLO_EN defined to exercise the brightness gating instead.
module tb_secuencia_leds;

  localparam int ANCHO = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  secuencia_leds_if #(.ANCHO(ANCHO)) bus ();

  secuencia_leds #(.ANCHO(ANCHO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string            tag;
    logic [ANCHO-1:0] leds;
    logic             ciclo;
  } esperado_t;

  esperado_t        sb[$];
  int               checks = 0;
  int               errors = 0;
  int               pulsos = 0;
  logic [ANCHO-1:0] esp_leds;

  // ciclo is high for a whole cycle, so one falling-edge sample per pulse
  always @(negedge clock) begin
    if (bus.ciclo === 1'b1) pulsos++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle paso, then verify: unchanged after 1 edge, new value after 2 edges,
  // ciclo back low one cycle later.
  task automatic paso_step(input string tag, input logic [ANCHO-1:0] e_leds,
                           input logic e_ciclo, input int gap);
    esperado_t e;
    e.tag = tag; e.leds = e_leds; e.ciclo = e_ciclo;
    sb.push_back(e);
    @(negedge clock);
    bus.paso = ~bus.paso;
    @(posedge clock); #1;
    check_val({tag, "_hold"}, 32'(bus.leds), 32'(esp_leds));
    @(posedge clock); #1;
    e = sb.pop_front();
    check_val({e.tag, "_leds"}, 32'(bus.leds), 32'(e.leds));
    check_val({e.tag, "_ciclo"}, 32'(bus.ciclo), 32'(e.ciclo));
    esp_leds = e.leds;
    @(posedge clock); #1;
    check_val({e.tag, "_ciclo_off"}, 32'(bus.ciclo), 32'(0));
    repeat (gap - 3) @(posedge clock);
  endtask

  task automatic set_modo(input logic [1:0] m, input logic [ANCHO-1:0] e_ini, input string tag);
    @(negedge clock);
    bus.modo = m;
    @(posedge clock); #1;
    check_val({tag, "_reload"}, 32'(bus.leds), 32'(e_ini));
    check_val({tag, "_reload_ciclo"}, 32'(bus.ciclo), 32'(0));
    esp_leds = e_ini;
    repeat (2) @(posedge clock);
  endtask

`ifdef LED_BRILLO_EN
  task automatic run_brillo();
    int altos;
    int base;
    bus.brillo = 4'd4;
    bus.modo   = 2'b11;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.paso = ~bus.paso;
    repeat (4) @(negedge clock);
    altos = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (bus.leds == 8'hFF) altos++;
      else check_val("brillo4_off", 32'(bus.leds), 32'h00);
    end
    check_val("brillo4_duty", 32'(altos), 32'd4);
    bus.brillo = 4'd0;
    repeat (3) @(negedge clock);
    altos = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (bus.leds != 8'h00) altos++;
    end
    check_val("brillo0_dark", 32'(altos), 32'd0);
    base = pulsos;
    @(negedge clock);
    bus.paso = ~bus.paso;
    @(posedge clock); @(posedge clock); #1;
    check_val("brillo_ciclo", 32'(bus.ciclo), 32'(1));
    repeat (4) @(posedge clock);
    check_val("brillo_pulsos", 32'(pulsos - base), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("brillo_rst_leds", 32'(bus.leds), 32'h01);
    check_val("brillo_rst_pwm", 32'(dut.pwm_cnt), 32'h0);
    check_val("brillo_rst_ciclo", 32'(bus.ciclo), 32'(0));
    @(negedge clock);
    reset = 1'b0;
  endtask
`endif

  task automatic run_main();
    logic [ANCHO-1:0] uno;
    logic [ANCHO-1:0] reb [14];
    int base;
    uno = 1;
    reb = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Rotate: 02,04,...,80,01 with one wrap pulse
    base = pulsos;
    for (int k = 1; k <= 8; k++)
      paso_step($sformatf("desplaza%0d", k), uno << (k % 8), k == 8, 10);
    check_val("desplaza_pulsos", 32'(pulsos - base), 32'd1);

    // Bounce: MSB shown once, wrap pulse on return to bit 0
    set_modo(2'b01, 8'h01, "rebote");
    base = pulsos;
    for (int k = 0; k < 14; k++)
      paso_step($sformatf("rebote%0d", k), reb[k], k == 13, 10);
    check_val("rebote_pulsos", 32'(pulsos - base), 32'd1);

    // Reload coinciding with a detected tick: tick dropped
    set_modo(2'b00, 8'h01, "desplaza2");
    for (int k = 1; k <= 4; k++)
      paso_step($sformatf("pre%0d", k), uno << k, 1'b0, 5);
    base = pulsos;
    @(negedge clock);
    bus.paso = ~bus.paso;
    @(posedge clock); #1;
    check_val("colision_hold", 32'(bus.leds), 32'h10);
    @(negedge clock);
    bus.modo = 2'b10;
    @(posedge clock); #1;
    check_val("colision_leds", 32'(bus.leds), 32'h00);
    check_val("colision_ciclo", 32'(bus.ciclo), 32'(0));
    repeat (4) @(posedge clock); #1;
    check_val("colision_dropped", 32'(bus.leds), 32'h00);
    check_val("colision_pulsos", 32'(pulsos - base), 32'd0);
    esp_leds = 8'h00;

    // Counter: 01..FF then 00 with a single wrap pulse
    base = pulsos;
    for (int k = 1; k <= 256; k++)
      paso_step($sformatf("contador%0d", k), ANCHO'(k), k == 256, 4);
    check_val("contador_pulsos", 32'(pulsos - base), 32'd1);
    paso_step("contador_extra", 8'h01, 1'b0, 4);

    // All-blink with pause: reload still happens, paused steps are lost
    @(negedge clock);
    bus.pausa = 1'b1;
    bus.modo  = 2'b11;
    @(posedge clock); #1;
    check_val("parpadeo_reload", 32'(bus.leds), 32'h00);
    esp_leds = 8'h00;
    base = pulsos;
    for (int k = 0; k < 5; k++)
      paso_step($sformatf("pausa%0d", k), 8'h00, 1'b0, 6);
    @(negedge clock);
    bus.pausa = 1'b0;
    repeat (3) @(posedge clock);
    paso_step("parpadeo_on", 8'hFF, 1'b0, 6);
    paso_step("parpadeo_off", 8'h00, 1'b1, 6);
    check_val("parpadeo_pulsos", 32'(pulsos - base), 32'd1);

    // Reset mid-pattern with a non-default mode selected
    set_modo(2'b00, 8'h01, "desplaza3");
    paso_step("mid1", 8'h02, 1'b0, 5);
    paso_step("mid2", 8'h04, 1'b0, 5);
    @(negedge clock);
    bus.modo = 2'b10;
    reset    = 1'b1;
    @(posedge clock); #1;
    check_val("rst_mid_leds", 32'(bus.leds), 32'h01);
    check_val("rst_mid_ciclo", 32'(bus.ciclo), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_val("rst_reload", 32'(bus.leds), 32'h00);
  endtask

  initial begin
    reset    = 1'b1;
    bus.paso  = 1'b0;
    bus.modo  = 2'b00;
    bus.pausa = 1'b0;
`ifdef LED_BRILLO_EN
    bus.brillo = 4'd15;
`endif
    esp_leds = 8'h01;
    repeat (3) @(posedge clock); #1;
    check_val("reset_leds", 32'(bus.leds), 32'h01);
    check_val("reset_ciclo", 32'(bus.ciclo), 32'(0));
`ifdef LED_BRILLO_EN
    run_brillo();
`else
    run_main();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/secuencia_leds.md
Name: secuencia_leds

Overview:
- Downstream consumer of the blinker's square-wave `salida` output.
- Each toggle of that signal (rising or falling edge) is one step of an 8-LED display pattern.
- Four selectable patterns: rotate, bounce, binary count, all-blink.
- Drives the DE0-Nano LED bank directly; emits a one-cycle pulse each time the pattern completes a full period.

Parameters:
- ANCHO, 8, number of LEDs / pattern width; legal values are 2 and above.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- paso  input  1  step source, the toggling output of the upstream blinker; every value change is one step
- modo  input  2  pattern select: 00 DESPLAZA, 01 REBOTE, 10 CONTADOR, 11 PARPADEO
- pausa  input  1  1 = steps are discarded, pattern frozen
- leds  output  ANCHO  LED drive, 1 = LED on
- ciclo  output  1  one-clock pulse when the pattern wraps to its initial value

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clock. On reset:
  - s1 = 0, s2 = 0, modo_q = 00
  - dir = up, patron = 1 (value 0…01)
  - leds = 0…01, ciclo = 0
- Step detect:
  - s1 <= paso; s2 <= s1; tick = (s1 != s2) & ~pausa.
  - If paso changes before edge k, leds updates at edge k+1. Latency is 2 clock edges.
  - Both paso polarities count as a step.
  - A tick arriving while pausa=1 is lost, not queued.
- Mode reload:
  - modo_q <= modo every cycle.
  - When modo != modo_q, next edge loads patron with the initial value of the new modo: DESPLAZA/REBOTE 0…01 with dir=up, CONTADOR 0, PARPADEO 0.
  - ciclo = 0 on a reload.
  - Reload has priority over a tick in the same cycle; that tick is dropped.
  - After reset with modo != 00, reload occurs on the first post-reset edge.
- Step rules, applied on an edge where tick=1 and no reload:
  - DESPLAZA: rotate left one bit. MSB wraps to bit0 and ciclo=1 on that edge. Period = ANCHO steps.
  - REBOTE: one-hot bit moves toward MSB while dir=up. On reaching MSB, dir flips to down and the next step moves toward bit0. On reaching bit0, dir flips to up and ciclo=1 on the step that lands on bit0. Period = 2*ANCHO-2 steps; no LED is held for two steps.
  - CONTADOR: patron+1 modulo 2^ANCHO. All-ones to 0 sets ciclo=1.
  - PARPADEO: patron = ~patron (all-off/all-on). The transition to all-off sets ciclo=1.
- Output timing:
  - ciclo is registered: high for exactly the one cycle following the wrap edge, otherwise 0.
  - leds is registered, driven from patron (or gated per the optional feature); it holds between ticks.
  - pausa does not affect mode reload.
- No other state.

Optional Feature:
- Macro LED_BRILLO_EN.
- Defined:
  - Adds input brillo [3:0] and a free-running 4-bit counter pwm_cnt (reset 0, +1 every clock, wraps 15 to 0).
  - leds = patron & {ANCHO{pwm_cnt < brillo}}.
  - brillo = 0 keeps LEDs off; brillo = 15 gives 15/16 duty.
  - Pattern stepping and ciclo are unaffected.
- Undefined: no brillo port, no counter; leds = patron.

Test Plan:
- Reset, modo=00, toggle paso 8 times, 10 clocks apart -> leds = 01,02,04,…,80,01 (hex). ciclo pulses once, 1 cycle after the 80 to 01 step. Each update occurs 2 edges after the paso change.
- modo=01, 14 toggles -> leds = 01,02,…,80,40,…,02,01. ciclo pulses once, on return to 01; 80 appears once only.
- modo=10, 256 toggles -> leds counts 00 to FF then 00. Exactly one ciclo, on the FF to 00 step.
- modo=11 with pausa=1, toggle paso 5 times -> leds stays 00. Release pausa and toggle once -> leds=FF. Toggle again -> leds=00 with ciclo=1.
- In DESPLAZA at leds=10, change modo to 10 on the same cycle a tick is detected -> leds=00 next edge. The tick is dropped; ciclo stays 0.
- With LED_BRILLO_EN: brillo=4, patron=FF -> leds high for 4 of every 16 clocks. brillo=0 -> leds=00 always. Apply reset mid-pattern -> leds=01 and pwm_cnt=0 on the following edge.
